// File: rtl/pla_sweep_ctrl.sv
// Exhaustive PLA sweep controller: drives every i-line vector, compares the PLA under test
// against a golden model, counts mismatches and folds all sampled f-lines into a MISR.
module pla_sweep_ctrl #(
  parameter int unsigned VEC_W  = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] pla_i,
  output logic        pla_cen,
  input  logic [7:0]  pla_f,
  input  logic [7:0]  ref_f,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        first_err_valid,
  output logic [15:0] first_err_addr,
  output logic [7:0]  first_err_f,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StCmp,
    StDone
  } state_e;

  localparam logic [VEC_W-1:0] LastAddr   = '1;
  // WAIT spans SETTLE cycles, so the counter is loaded with SETTLE-1 and exits at zero.
  localparam logic [3:0]       SettleLoad = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] addr_q, addr_d;
  logic [3:0]       settle_q, settle_d;
  logic [15:0]      err_q, err_d;
  logic             fev_q, fev_d;
  logic [15:0]      fea_q, fea_d;
  logic [7:0]       fef_q, fef_d;
  logic [15:0]      sig_q, sig_d;

  logic accept;
  logic in_sweep;
  logic mismatch;

  assign in_sweep = (state_q == StDrive) || (state_q == StWait) || (state_q == StCmp);
  assign accept   = ((state_q == StIdle) || (state_q == StDone)) && start && !abort;
  assign mismatch = (pla_f != ref_f);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) state_d = StDrive;
      end
      StDrive: begin
        if (abort)           state_d = StIdle;
        else if (SETTLE > 0) state_d = StWait;
        else                 state_d = StCmp;
      end
      StWait: begin
        if (abort)                 state_d = StIdle;
        else if (settle_q == 4'd0) state_d = StCmp;
      end
      StCmp: begin
        if (abort)                   state_d = StIdle;
        else if (addr_q == LastAddr) state_d = StDone;
        else                         state_d = StDrive;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    settle_d = settle_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fea_d    = fea_q;
    fef_d    = fef_q;
    sig_d    = sig_q;
    if (accept) begin
      addr_d = '0;
      err_d  = 16'h0000;
      fev_d  = 1'b0;
      fea_d  = 16'h0000;
      fef_d  = 8'h00;
      sig_d  = 16'hFFFF;
    end else if (in_sweep && !abort) begin
      unique case (state_q)
        StDrive: settle_d = SettleLoad;
        StWait: begin
          if (settle_q != 4'd0) settle_d = settle_q - 4'd1;
        end
        StCmp: begin
          sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ {8'h00, pla_f};
          if (mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (!fev_q) begin
              fev_d = 1'b1;
              fea_d = 16'(addr_q);
              fef_d = pla_f;
            end
          end
          // Address stops at the last vector rather than wrapping back to zero.
          if (addr_q != LastAddr) addr_d = addr_q + VEC_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      settle_q <= 4'd0;
      err_q    <= 16'h0000;
      fev_q    <= 1'b0;
      fea_q    <= 16'h0000;
      fef_q    <= 8'h00;
      sig_q    <= 16'hFFFF;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fea_q    <= fea_d;
      fef_q    <= fef_d;
      sig_q    <= sig_d;
    end
  end

  assign busy            = in_sweep;
  assign done            = (state_q == StDone);
  assign pass            = done && (err_q == 16'h0000);
  assign pla_i           = in_sweep ? 16'(addr_q) : 16'h0000;
  assign pla_cen         = !in_sweep;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;
  assign first_err_f     = fef_q;
  assign signature       = sig_q;

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Scoreboard bench for pla_sweep_ctrl with VEC_W=4, SETTLE=1 and a behavioural PLA pair.
module tb_pla_sweep_ctrl;

  localparam int NVEC = 16;
  localparam int P    = 3;  // cycles per vector: DRIVE + 1 WAIT + CMP

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] pla_i;
  logic        pla_cen;
  logic [7:0]  pla_f, ref_f;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic        first_err_valid;
  logic [15:0] first_err_addr;
  logic [7:0]  first_err_f;
  logic [15:0] signature;

  int total = 0;
  int bad   = 0;
  int mode  = 0;  // 0: matched, 1: fault at vector 5 only, 2: every vector differs

  typedef struct {
    logic [15:0] err;
    logic [15:0] sig;
    logic        fev;
    logic [15:0] fea;
    logic [7:0]  fef;
    logic        pass;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pla_sweep_ctrl #(
    .VEC_W (4),
    .SETTLE(1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .pla_i          (pla_i),
    .pla_cen        (pla_cen),
    .pla_f          (pla_f),
    .ref_f          (ref_f),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_valid(first_err_valid),
    .first_err_addr (first_err_addr),
    .first_err_f    (first_err_f),
    .signature      (signature)
  );

  function automatic logic [7:0] gold(input logic [15:0] a);
    gold = 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] dut_pla(input int m, input logic [15:0] a);
    logic [7:0] g;
    g = gold(a);
    if (m == 1)      dut_pla = (a == 16'd5) ? 8'hA5 : g;
    else if (m == 2) dut_pla = ~g;
    else             dut_pla = g;
  endfunction

  always_comb begin
    ref_f = gold(pla_i);
    pla_f = dut_pla(mode, pla_i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // abort_at / extra_start_at are cycle numbers relative to the start cycle (0); -1 disables.
  task automatic run_sweep(input int m, input int abort_at, input int extra_start_at,
                           input string name);
    exp_t        e;
    exp_t        got;
    logic [7:0]  pf;
    logic [15:0] ev;
    int          last;
    int          errs;
    logic        eb, ed;
    logic [15:0] ei;
    e.sig = 16'hFFFF;
    e.fev = 1'b0;
    e.fea = 16'h0;
    e.fef = 8'h0;
    errs  = 0;
    for (int k = 0; k < NVEC; k++) begin
      if (abort_at < 0 || P * (k + 1) < abort_at) begin
        ev = 16'(k);
        pf = dut_pla(m, ev);
        e.sig = {e.sig[14:0], e.sig[15] ^ e.sig[13] ^ e.sig[12] ^ e.sig[10]} ^ {8'h00, pf};
        if (pf != gold(ev)) begin
          if (errs < 65535) errs++;
          if (!e.fev) begin
            e.fev = 1'b1;
            e.fea = ev;
            e.fef = pf;
          end
        end
      end
    end
    e.err  = 16'(errs);
    e.pass = (abort_at < 0) && (errs == 0);
    sb.push_back(e);

    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    last  = (abort_at >= 0) ? abort_at + 4 : NVEC * P + 6;
    for (int c = 1; c <= last; c++) begin
      abort = (c == abort_at);
      start = (c == extra_start_at);
      eb = (c <= ((abort_at >= 0) ? abort_at : NVEC * P));
      ed = (abort_at < 0) && (c > NVEC * P);
      ei = eb ? 16'((c - 1) / P) : 16'h0;
      total += 4;
      if (busy !== eb) begin
        bad++;
        $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, busy, eb);
      end
      if (done !== ed) begin
        bad++;
        $display("FAIL %s done c=%0d got=%b exp=%b", name, c, done, ed);
      end
      if (pla_cen !== !eb) begin
        bad++;
        $display("FAIL %s pla_cen c=%0d got=%b exp=%b", name, c, pla_cen, !eb);
      end
      if (pla_i !== ei) begin
        bad++;
        $display("FAIL %s pla_i c=%0d got=%h exp=%h", name, c, pla_i, ei);
      end
      tick();
    end
    abort = 1'b0;
    start = 1'b0;

    got = sb.pop_front();
    total += 6;
    if (err_count !== got.err) begin
      bad++;
      $display("FAIL %s err_count got=%h exp=%h", name, err_count, got.err);
    end
    if (signature !== got.sig) begin
      bad++;
      $display("FAIL %s signature got=%h exp=%h", name, signature, got.sig);
    end
    if (first_err_valid !== got.fev) begin
      bad++;
      $display("FAIL %s first_err_valid got=%b exp=%b", name, first_err_valid, got.fev);
    end
    if (first_err_addr !== got.fea) begin
      bad++;
      $display("FAIL %s first_err_addr got=%h exp=%h", name, first_err_addr, got.fea);
    end
    if (first_err_f !== got.fef) begin
      bad++;
      $display("FAIL %s first_err_f got=%h exp=%h", name, first_err_f, got.fef);
    end
    if (pass !== got.pass) begin
      bad++;
      $display("FAIL %s pass got=%b exp=%b", name, pass, got.pass);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    tick();
    tick();
    start = 1'b0;
    total += 10;
    if (pla_i !== 16'h0) begin bad++; $display("FAIL reset pla_i got=%h exp=0", pla_i); end
    if (pla_cen !== 1'b1) begin bad++; $display("FAIL reset pla_cen got=%b exp=1", pla_cen); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b exp=0", done); end
    if (pass !== 1'b0) begin bad++; $display("FAIL reset pass got=%b exp=0", pass); end
    if (err_count !== 16'h0) begin
      bad++; $display("FAIL reset err_count got=%h exp=0", err_count);
    end
    if (first_err_valid !== 1'b0) begin
      bad++; $display("FAIL reset first_err_valid got=%b exp=0", first_err_valid);
    end
    if (first_err_addr !== 16'h0) begin
      bad++; $display("FAIL reset first_err_addr got=%h exp=0", first_err_addr);
    end
    if (first_err_f !== 8'h0) begin
      bad++; $display("FAIL reset first_err_f got=%h exp=0", first_err_f);
    end
    if (signature !== 16'hFFFF) begin
      bad++; $display("FAIL reset signature got=%h exp=ffff", signature);
    end
    // Start coincident with the last reset cycle must not launch a sweep.
    rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_start busy got=%b exp=0", busy); end
  endtask

  task automatic test_matched();
    run_sweep(0, -1, 10, "matched");
  endtask

  task automatic test_single_fault();
    run_sweep(1, -1, -1, "single_fault");
  endtask

  task automatic test_all_fault();
    run_sweep(2, -1, -1, "all_fault");
  endtask

  task automatic test_back_to_back();
    run_sweep(0, -1, -1, "back_to_back");
  endtask

  task automatic test_abort();
    run_sweep(2, 20, -1, "abort");
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    tick();
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_start busy got=%b exp=0", busy); end
    if (err_count !== 16'd6) begin
      bad++; $display("FAIL abort_start err_count got=%h exp=6", err_count);
    end
    run_sweep(0, -1, -1, "rerun_after_abort");
  endtask

  task automatic test_reset_mid();
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 30; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 6;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid busy got=%b exp=0", busy); end
    if (pla_cen !== 1'b1) begin bad++; $display("FAIL reset_mid pla_cen got=%b exp=1", pla_cen); end
    if (pla_i !== 16'h0) begin bad++; $display("FAIL reset_mid pla_i got=%h exp=0", pla_i); end
    if (err_count !== 16'h0) begin
      bad++; $display("FAIL reset_mid err_count got=%h exp=0", err_count);
    end
    if (first_err_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid first_err_valid got=%b exp=0", first_err_valid);
    end
    if (signature !== 16'hFFFF) begin
      bad++; $display("FAIL reset_mid signature got=%h exp=ffff", signature);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    test_reset();
    test_matched();
    test_single_fault();
    test_all_fault();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
